// File: rtl/tail_light_seq.sv
// Sequential walking turn-signal tail-light controller.
// Supports hazard blinking, a brake override and a step prescaler.
module tail_light_seq #(
  parameter int LIGHTS = 3,
  parameter int DIV    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  left,
  input  logic                  right,
  input  logic                  brake,
  output logic [2*LIGHTS-1:0]   y,
  output logic                  busy
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = $clog2(LIGHTS + 1);
  localparam int NL = 2 * LIGHTS;

  typedef enum logic [1:0] {
    M_IDLE,
    M_LEFT,
    M_RIGHT,
    M_HAZ
  } mode_t;

  mode_t             mode;
  mode_t             mode_n;
  logic [IW-1:0]     idx;
  logic [IW-1:0]     idx_n;
  logic [CW-1:0]     cnt;
  logic              step;
  logic              brake_q;
  logic [LIGHTS-1:0] walk;
  logic [LIGHTS-1:0] lbank;
  logic [LIGHTS-1:0] rbank;
  logic [NL-1:0]     y_n;

  assign step = (cnt == CW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      mode    <= M_IDLE;
      idx     <= '0;
      cnt     <= '0;
      brake_q <= 1'b0;
      y       <= '0;
      busy    <= 1'b0;
    end else begin
      mode    <= mode_n;
      idx     <= idx_n;
      cnt     <= step ? '0 : cnt + CW'(1);
      brake_q <= brake;
      y       <= y_n;
      busy    <= (mode_n != M_IDLE);
    end
  end

  // Requests are only looked at from IDLE; running sequences always complete.
  always_comb begin
    mode_n = mode;
    idx_n  = idx;
    if (step) begin
      unique case (mode)
        M_IDLE: begin
          unique case (1'b1)
            left && right: begin
              mode_n = M_HAZ;
              idx_n  = '0;
            end
            left && !right: begin
              mode_n = M_LEFT;
              idx_n  = IW'(1);
            end
            right && !left: begin
              mode_n = M_RIGHT;
              idx_n  = IW'(1);
            end
            default: begin
              mode_n = M_IDLE;
              idx_n  = '0;
            end
          endcase
        end
        M_LEFT, M_RIGHT: begin
          if (idx == IW'(LIGHTS)) begin
            mode_n = M_IDLE;
            idx_n  = '0;
          end else begin
            idx_n = idx + IW'(1);
          end
        end
        M_HAZ: begin
          mode_n = M_IDLE;
          idx_n  = '0;
        end
        default: begin
          mode_n = M_IDLE;
          idx_n  = '0;
        end
      endcase
    end
  end

  // Bit 0 of walk is the innermost lamp (LA / RA) of a bank.
  always_comb begin
    walk = '0;
    for (int i = 0; i < LIGHTS; i++) begin
      walk[i] = (i < int'(idx_n));
    end
  end

  always_comb begin
    lbank = '0;
    rbank = '0;
    unique case (mode_n)
      M_IDLE: begin
        lbank = {LIGHTS{brake_q}};
        rbank = {LIGHTS{brake_q}};
      end
      M_LEFT: begin
        lbank = walk;
        rbank = {LIGHTS{brake_q}};
      end
      M_RIGHT: begin
        lbank = {LIGHTS{brake_q}};
        rbank = walk;
      end
      M_HAZ: begin
        lbank = '1;
        rbank = '1;
      end
      default: begin
        lbank = '0;
        rbank = '0;
      end
    endcase
  end

  // Left bank grows upward from y[L]; right bank grows downward from y[L-1].
  always_comb begin
    y_n = '0;
    for (int i = 0; i < LIGHTS; i++) begin
      y_n[LIGHTS + i]     = lbank[i];
      y_n[LIGHTS - 1 - i] = rbank[i];
    end
  end

endmodule

// File: tb/tb_tail_light_seq.sv
// Scoreboard bench for tail_light_seq: two configurations run in
// parallel on shared stimulus against a behavioural lamp model.
module tb_tail_light_seq;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       left = 1'b0;
  logic       right = 1'b0;
  logic       brake = 1'b0;
  logic [5:0] ya;
  logic       busya;
  logic [7:0] yb;
  logic       busyb;

  int total = 0;
  int bad = 0;

  logic [8:0] qa[$];
  logic [8:0] qb[$];

  int side[2];
  int k[2];
  int cnt[2];
  bit bq[2];
  int ll[2] = '{3, 4};
  int dd[2] = '{1, 4};

  always #5 clk = ~clk;

  tail_light_seq #(.LIGHTS(3), .DIV(1)) u_a (
    .clk(clk), .reset(reset), .left(left), .right(right),
    .brake(brake), .y(ya), .busy(busya)
  );

  tail_light_seq #(.LIGHTS(4), .DIV(4)) u_b (
    .clk(clk), .reset(reset), .left(left), .right(right),
    .brake(brake), .y(yb), .busy(busyb)
  );

  // side: 0 idle, 1 left, 2 right, 3 hazard; k = lamps lit on the walking side
  task automatic model(input int n, input bit r, input bit l,
                       input bit rt, input bit b,
                       output logic [8:0] e);
    int L;
    int full;
    int mask;
    int yv;
    bit st;
    L = ll[n];
    if (r) begin
      side[n] = 0; k[n] = 0; cnt[n] = 0; bq[n] = 0;
      e = '0;
      return;
    end
    st = (cnt[n] == dd[n] - 1);
    cnt[n] = st ? 0 : cnt[n] + 1;
    if (st) begin
      if (side[n] == 0) begin
        if (l && rt) side[n] = 3;
        else if (l) begin side[n] = 1; k[n] = 1; end
        else if (rt) begin side[n] = 2; k[n] = 1; end
      end else if (side[n] == 3) begin
        side[n] = 0;
      end else if (k[n] == L) begin
        side[n] = 0; k[n] = 0;
      end else begin
        k[n] = k[n] + 1;
      end
    end
    full = (1 << L) - 1;
    mask = (1 << k[n]) - 1;
    case (side[n])
      1: yv = (mask << L) | (bq[n] ? full : 0);
      2: yv = (mask << (L - k[n])) | (bq[n] ? (full << L) : 0);
      3: yv = (full << L) | full;
      default: yv = bq[n] ? ((full << L) | full) : 0;
    endcase
    bq[n] = b;
    e = {side[n] != 0, 8'(yv)};
  endtask

  task automatic drive(input bit r, input bit l, input bit rt,
                       input bit b, input int n);
    logic [8:0] e;
    for (int i = 0; i < n; i++) begin
      reset = r; left = l; right = rt; brake = b;
      model(0, r, l, rt, b, e);
      qa.push_back(e);
      model(1, r, l, rt, b, e);
      qb.push_back(e);
      @(negedge clk);
    end
  endtask

  always @(posedge clk) begin
    logic [8:0] e;
    #1;
    if (qa.size() != 0) begin
      e = qa.pop_front();
      total++;
      if (ya !== e[5:0]) begin
        bad++;
        $display("FAIL y_a t=%0t got=%b want=%b", $time, ya, e[5:0]);
      end
      total++;
      if (busya !== e[8]) begin
        bad++;
        $display("FAIL busy_a t=%0t got=%b want=%b", $time, busya, e[8]);
      end
    end
    if (qb.size() != 0) begin
      e = qb.pop_front();
      total++;
      if (yb !== e[7:0]) begin
        bad++;
        $display("FAIL y_b t=%0t got=%b want=%b", $time, yb, e[7:0]);
      end
      total++;
      if (busyb !== e[8]) begin
        bad++;
        $display("FAIL busy_b t=%0t got=%b want=%b", $time, busyb, e[8]);
      end
    end
  end

  initial begin
    drive(1, 0, 0, 0, 2);
    drive(0, 0, 0, 0, 5);
    drive(0, 1, 0, 0, 8);
    drive(0, 1, 0, 0, 2);
    drive(0, 0, 0, 0, 4);
    drive(0, 0, 1, 0, 5);
    drive(0, 1, 1, 0, 4);
    drive(0, 0, 0, 0, 2);
    drive(0, 1, 0, 0, 1);
    drive(0, 1, 1, 0, 6);
    drive(0, 0, 0, 0, 3);
    drive(0, 0, 0, 1, 3);
    drive(0, 1, 0, 1, 6);
    drive(0, 1, 1, 1, 6);
    drive(0, 0, 0, 0, 3);
    drive(0, 1, 0, 0, 2);
    drive(1, 1, 0, 0, 1);
    drive(0, 1, 0, 0, 4);
    drive(0, 0, 0, 0, 4);
    drive(0, 1, 0, 0, 25);
    drive(0, 0, 0, 0, 20);
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 99) == 0,
            $urandom_range(0, 2) == 0,
            $urandom_range(0, 2) == 0,
            $urandom_range(0, 3) == 0, 1);
    end
    @(posedge clk);
    #3;
    total++;
    if (qa.size() != 0 || qb.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d/%0d want=0/0", qa.size(), qb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
